uart_frame_sched: RTL and testbench

Frame scheduler sitting between the point-detection logic and the UART transmitter. On a frame trigger it snapshots up to N tracked points and sequences them through the UART TX one byte at a time, driving the data-valid strobe and waiting for each TX_DONE. Each frame is framed as 'S', payload, optional checksum, then 'E'. Triggers that arrive while a frame is still in flight are dropped and counted.

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_byte_mux.sv | 52 +++++
 rtl/uart_frame_sched.sv | 155 +++++++++++++++
 tb/tb_uart_frame_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame scheduler.
// Optional feature macro: UART_FRAME_CHKSUM_EN (adds an XOR checksum byte before 'E').
package uart_frame_pkg;

  localparam logic [7:0] SOF_BYTE = 8'h53;  // 'S'
  localparam logic [7:0] EOF_BYTE = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SEND,
    WAIT_DONE,
    GAP
  } state_t;

  // Total bytes per frame: 'S' + 4 bytes per point (+ checksum) + 'E'.
  function automatic int frame_len(input int n_points);
`ifdef UART_FRAME_CHKSUM_EN
    return 4 * n_points + 3;
`else
    return 4 * n_points + 2;
`endif
  endfunction

endpackage

// File: rtl/uart_frame_byte_mux.sv
// Combinational byte selector: maps a frame byte index onto 'S', the snapshot
// payload (H hi, H lo, V hi, V lo per point), the checksum and 'E'.
// Optional feature macro: UART_FRAME_CHKSUM_EN.
module uart_frame_byte_mux
  import uart_frame_pkg::*;
#(
  parameter int N_POINTS = 8
) (
  input  logic [16*N_POINTS-1:0] snap_h,
  input  logic [16*N_POINTS-1:0] snap_v,
  input  logic [6:0]             idx,
`ifdef UART_FRAME_CHKSUM_EN
  input  logic [7:0]             chk,
  output logic                   is_payload,
`endif
  output logic [7:0]             byte_out
);

  localparam int PAYLOAD = 4 * N_POINTS;

  logic [6:0]  pidx;
  logic [15:0] word;
  logic        in_payload;

  // Select the coordinate word for the payload byte, then the byte within it.
  always_comb begin
    pidx       = idx - 7'd1;
    word       = 16'h0000;
    in_payload = (idx != 7'd0) && (idx <= 7'(PAYLOAD));
    for (int p = 0; p < N_POINTS; p++) begin
      if (pidx[6:2] == 5'(p)) begin
        word = pidx[1] ? snap_v[16*p +: 16] : snap_h[16*p +: 16];
      end
    end
    if (idx == 7'd0) begin
      byte_out = SOF_BYTE;
    end else if (in_payload) begin
      byte_out = pidx[0] ? word[7:0] : word[15:8];
`ifdef UART_FRAME_CHKSUM_EN
    end else if (idx == 7'(PAYLOAD + 1)) begin
      byte_out = chk;
`endif
    end else begin
      byte_out = EOF_BYTE;
    end
  end

`ifdef UART_FRAME_CHKSUM_EN
  assign is_payload = in_payload;
`endif

endmodule

// File: rtl/uart_frame_sched.sv
// Frame scheduler: snapshots N_POINTS points on FRAME_START and streams them
// to a UART TX as 'S', payload, [checksum], 'E'.
// Optional feature macro: UART_FRAME_CHKSUM_EN (XOR checksum byte before 'E').
//
// TX handshake: TX_DV is a one-cycle strobe with TX_BYTE valid in that cycle
// and held until the next strobe; the TX answers with a one-cycle TX_DONE,
// and no further TX_DV is issued until that TX_DONE (plus GAP_CYCLES) is seen.
module uart_frame_sched
  import uart_frame_pkg::*;
#(
  parameter int N_POINTS   = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   FRAME_START,
  input  logic [16*N_POINTS-1:0] POINTS_H,
  input  logic [16*N_POINTS-1:0] POINTS_V,
  input  logic                   TX_DONE,
  output logic                   TX_DV,
  output logic [7:0]             TX_BYTE,
  output logic                   BUSY,
  output logic [7:0]             DROP_CNT,
  output state_t                 state_dbg
);

  localparam logic [6:0]  LAST_IDX = 7'(frame_len(N_POINTS) - 1);
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

  state_t                 state, state_nx;
  logic [6:0]             idx, idx_nx;
  logic [15:0]            gap_cnt, gap_nx;
  logic [16*N_POINTS-1:0] snap_h, snap_v;
  logic [7:0]             mux_byte;
`ifdef UART_FRAME_CHKSUM_EN
  logic [7:0]             chk;
  logic                   is_payload;
`endif

  // The mux looks at the next index so TX_BYTE can be registered together
  // with TX_DV on entry into SEND.
  uart_frame_byte_mux #(
    .N_POINTS(N_POINTS)
  ) u_byte_mux (
    .snap_h    (snap_h),
    .snap_v    (snap_v),
    .idx       (idx_nx),
`ifdef UART_FRAME_CHKSUM_EN
    .chk       (chk),
    .is_payload(is_payload),
`endif
    .byte_out  (mux_byte)
  );

  // Next-state, index and gap-counter logic.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    gap_nx   = gap_cnt;
    case (state)
      IDLE: begin
        if (FRAME_START) state_nx = LATCH;
      end
      LATCH: begin
        idx_nx   = 7'd0;
        state_nx = SEND;
      end
      SEND: begin
        state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (TX_DONE) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 7'd1;
            if (GAP_CYCLES > 0) begin
              state_nx = GAP;
              gap_nx   = GAP_LOAD;
            end else begin
              state_nx = SEND;
            end
          end
        end
      end
      GAP: begin
        if (gap_cnt == 16'd0) state_nx = SEND;
        else                  gap_nx   = gap_cnt - 16'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, index and gap counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      idx     <= 7'd0;
      gap_cnt <= 16'd0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      gap_cnt <= gap_nx;
    end
  end

  // Registered outputs: strobe and byte are loaded on entry into SEND.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      TX_DV   <= 1'b0;
      TX_BYTE <= 8'h00;
      BUSY    <= 1'b0;
    end else begin
      TX_DV <= (state_nx == SEND);
      BUSY  <= (state_nx != IDLE);
      if (state_nx == SEND) TX_BYTE <= mux_byte;
    end
  end

  // Point snapshot, taken once per frame in LATCH.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_h <= '0;
      snap_v <= '0;
    end else if (state == LATCH) begin
      snap_h <= POINTS_H;
      snap_v <= POINTS_V;
    end
  end

`ifdef UART_FRAME_CHKSUM_EN
  // Running XOR of payload bytes, folded in as each one is loaded for sending.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chk <= 8'h00;
    end else if (state == LATCH) begin
      chk <= 8'h00;
    end else if ((state_nx == SEND) && is_payload) begin
      chk <= chk ^ mux_byte;
    end
  end
`endif

  // Saturating count of triggers that arrive while a frame is in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DROP_CNT <= 8'd0;
    end else if (FRAME_START && (state != IDLE) && (DROP_CNT != 8'hFF)) begin
      DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched: one instance with no gap (main frames,
// snapshot, overrun, reset) and one with GAP_CYCLES=5 (gap timing).
module tb_uart_frame_sched;
  import uart_frame_pkg::*;

  localparam int NP = 2;
`ifdef UART_FRAME_CHKSUM_EN
  localparam int FRAME_L = 4 * NP + 3;
`else
  localparam int FRAME_L = 4 * NP + 2;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic [16*NP-1:0] POINTS_H = '0;
  logic [16*NP-1:0] POINTS_V = '0;

  logic         FRAME_START = 1'b0, TX_DONE = 1'b0;
  logic         TX_DV, BUSY;
  logic [7:0]   TX_BYTE, DROP_CNT;
  state_t       state_dbg;

  logic         fs_g = 1'b0, done_g = 1'b0;
  logic         dv_g, busy_g;
  logic [7:0]   byte_g, drop_g;
  state_t       state_g;

  uart_frame_sched #(.N_POINTS(NP), .GAP_CYCLES(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .FRAME_START(FRAME_START),
    .POINTS_H(POINTS_H), .POINTS_V(POINTS_V), .TX_DONE(TX_DONE),
    .TX_DV(TX_DV), .TX_BYTE(TX_BYTE), .BUSY(BUSY), .DROP_CNT(DROP_CNT),
    .state_dbg(state_dbg)
  );

  uart_frame_sched #(.N_POINTS(NP), .GAP_CYCLES(5)) dut_g (
    .CLK(CLK), .RST_N(RST_N), .FRAME_START(fs_g),
    .POINTS_H(POINTS_H), .POINTS_V(POINTS_V), .TX_DONE(done_g),
    .TX_DV(dv_g), .TX_BYTE(byte_g), .BUSY(busy_g), .DROP_CNT(drop_g),
    .state_dbg(state_g)
  );

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [15:0] h_pt[NP];
  logic [15:0] v_pt[NP];
  int checks = 0;
  int errors = 0;

  task automatic do_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte k of a frame built from h_pt/v_pt.
  function automatic logic [7:0] byte_at(input int k);
    logic [7:0] pl[4*NP];
    logic [7:0] x;
    x = 8'h00;
    for (int p = 0; p < NP; p++) begin
      pl[4*p]   = h_pt[p][15:8];
      pl[4*p+1] = h_pt[p][7:0];
      pl[4*p+2] = v_pt[p][15:8];
      pl[4*p+3] = v_pt[p][7:0];
    end
    for (int i = 0; i < 4*NP; i++) x = x ^ pl[i];
    if (k == 0)                 return 8'h53;
    else if (k <= 4*NP)         return pl[k-1];
    else if (k == FRAME_L - 1)  return 8'h45;
    else                        return x;
  endfunction

  function automatic void push_frame();
    for (int k = 0; k < FRAME_L; k++) exp_q.push_back(byte_at(k));
  endfunction

  // Every TX_DV of the main instance consumes one expected byte.
  always @(negedge CLK) begin
    if (TX_DV) begin
      if (exp_q.size() == 0) begin
        do_check("unexpected_tx_dv", 32'(TX_BYTE), 32'hFFFF);
      end else begin
        do_check("tx_byte", 32'(TX_BYTE), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_dv(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!TX_DV && n < 300);
    if (!TX_DV) do_check(tag, 0, 1);
  endtask

  // Trigger a frame and check the start latency (BUSY next cycle, TX_DV after).
  task automatic start_frame();
    FRAME_START = 1'b1;
    @(posedge CLK); #1;
    FRAME_START = 1'b0;
    do_check("busy_after_start", BUSY, 1);
    do_check("no_dv_in_latch", TX_DV, 0);
    @(posedge CLK); #1;
    do_check("first_dv", TX_DV, 1);
  endtask

  // Act as the UART: answer nbytes strobes with TX_DONE lat cycles later.
  task automatic serve(input int nbytes, input int lat, input bit mangle, input bit fs_last);
    for (int k = 0; k < nbytes; k++) begin
      wait_dv("dv_timeout");
      if (mangle && k == 0) POINTS_H[15:0] = 16'hFFFF;
      repeat (lat) @(posedge CLK);
      #1 TX_DONE = 1'b1;
      if (k == FRAME_L - 1) begin
        do_check("busy_before_last_done", BUSY, 1);
        if (fs_last) FRAME_START = 1'b1;
      end
      @(posedge CLK); #1;
      TX_DONE = 1'b0;
      if (fs_last && k == FRAME_L - 1) FRAME_START = 1'b0;
      if (k == FRAME_L - 1) do_check("busy_after_last_done", BUSY, 0);
      else                  do_check("done_to_dv", TX_DV, 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    h_pt[0] = 16'h0123; v_pt[0] = 16'h0456;
    h_pt[1] = 16'h0789; v_pt[1] = 16'h0ABC;
    POINTS_H = {h_pt[1], h_pt[0]};
    POINTS_V = {v_pt[1], v_pt[0]};

    // Reset state
    repeat (3) @(negedge CLK);
    do_check("rst_tx_dv", TX_DV, 0);
    do_check("rst_tx_byte", TX_BYTE, 0);
    do_check("rst_busy", BUSY, 0);
    do_check("rst_drop_cnt", DROP_CNT, 0);
    do_check("rst_state", state_dbg, IDLE);
    do_check("rst_busy_g", busy_g, 0);
    RST_N = 1'b1;

    // Gap instance: 5 idle cycles after each TX_DONE, spurious TX_DONE in GAP
    @(posedge CLK); #1 fs_g = 1'b1;
    @(posedge CLK); #1 fs_g = 1'b0;
    do_check("busy_g_after_start", busy_g, 1);
    @(posedge CLK); #1;
    for (int k = 0; k < FRAME_L; k++) begin
      do_check("gap_dv", dv_g, 1);
      do_check("gap_byte", byte_g, byte_at(k));
      repeat (3) @(posedge CLK);
      #1 done_g = 1'b1;
      @(posedge CLK); #1 done_g = 1'b0;
      if (k == FRAME_L - 1) begin
        do_check("gap_busy_end", busy_g, 0);
      end else begin
        for (int j = 0; j < 5; j++) begin
          do_check("gap_quiet", dv_g, 0);
          done_g = (k == 0 && j == 1);
          @(posedge CLK); #1;
        end
        done_g = 1'b0;
      end
    end

    // Frame A: basic content, snapshot held while inputs change,
    // trigger coinciding with final TX_DONE is dropped
    @(posedge CLK); #1;
    push_frame();
    start_frame();
    serve(FRAME_L, 10, 1'b1, 1'b1);
    do_check("drop_on_last_done", DROP_CNT, 1);
    do_check("queue_empty_a", exp_q.size(), 0);

    // Frame B: trigger right after BUSY falls is accepted; 300 overrun pulses
    POINTS_H = {h_pt[1], h_pt[0]};
    push_frame();
    start_frame();
    fork
      serve(FRAME_L, 70, 1'b0, 1'b0);
      begin
        repeat (300) begin
          FRAME_START = 1'b1;
          @(posedge CLK); #1;
          FRAME_START = 1'b0;
          @(posedge CLK); #1;
        end
      end
    join
    repeat (20) @(posedge CLK);
    #1;
    do_check("overrun_drop_sat", DROP_CNT, 255);
    do_check("overrun_busy", BUSY, 0);
    do_check("queue_empty_b", exp_q.size(), 0);

    // Frame C: reset after the 4th TX_DV
    push_frame();
    start_frame();
    serve(3, 10, 1'b0, 1'b0);
    wait_dv("dv_timeout_c");
    #1 RST_N = 1'b0;
    #1;
    do_check("midrst_tx_dv", TX_DV, 0);
    do_check("midrst_busy", BUSY, 0);
    do_check("midrst_tx_byte", TX_BYTE, 0);
    do_check("midrst_drop_cnt", DROP_CNT, 0);
    do_check("midrst_consumed", exp_q.size(), FRAME_L - 4);
    exp_q.delete();
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    // The in-flight byte's TX_DONE arrives after reset and must be ignored
    @(posedge CLK); #1 TX_DONE = 1'b1;
    @(posedge CLK); #1 TX_DONE = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    do_check("stray_done_busy", BUSY, 0);
    do_check("stray_done_state", state_dbg, IDLE);

    // Frame D: full frame after reset
    push_frame();
    start_frame();
    serve(FRAME_L, 3, 1'b0, 1'b0);
    do_check("queue_empty_d", exp_q.size(), 0);
    do_check("final_drop_cnt", DROP_CNT, 0);

    repeat (5) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
